// File: rtl/prbs10_checker.sv
// Receive-side checker for the 10-bit XNOR LFSR stream (feedback ~(s[9]^s[6])).
// Self-synchronises, declares lock, then flywheels its prediction and counts bit errors.
module prbs10_checker #(
  parameter int unsigned LOCK_COUNT  = 16,
  parameter int unsigned WINDOW      = 32,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {StFill, StSearch, StLocked} state_t;

  state_t           r_state;
  logic [9:0]       r_hist;
  logic [3:0]       r_fill_cnt;
  logic [7:0]       r_match_cnt;
  logic [7:0]       r_win_cnt;
  logic [7:0]       r_win_err;
  logic             r_locked;
  logic             r_err_pulse;
  logic [ERR_W-1:0] r_err_count;

  logic       w_pred;
  logic       w_mis;
  logic [7:0] w_win_err_nxt;

  assign w_pred        = ~(r_hist[9] ^ r_hist[6]);
  assign w_mis         = bit_in ^ w_pred;
  assign w_win_err_nxt = r_win_err + 8'(w_mis);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StFill;
      r_hist      <= '0;
      r_fill_cnt  <= '0;
      r_match_cnt <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      if (clear_err) r_err_count <= '0;
      if (bit_valid) begin
        case (r_state)
          StFill: begin
            r_hist <= {r_hist[8:0], bit_in};
            if (r_fill_cnt == 4'd9) begin
              r_state     <= StSearch;
              r_fill_cnt  <= '0;
              r_match_cnt <= '0;
            end else begin
              r_fill_cnt <= r_fill_cnt + 4'd1;
            end
          end
          StSearch: begin
            r_hist <= {r_hist[8:0], bit_in};
            // All-ones history is the XNOR lock-up state and can never be a valid alignment.
            if (r_hist == 10'h3FF) begin
              r_match_cnt <= '0;
            end else if (!w_mis) begin
              r_match_cnt <= r_match_cnt + 8'd1;
              if (r_match_cnt == 8'(LOCK_COUNT - 1)) begin
                r_state   <= StLocked;
                r_locked  <= 1'b1;
                r_win_cnt <= '0;
                r_win_err <= '0;
              end
            end else begin
              r_match_cnt <= '0;
            end
          end
          StLocked: begin
            // Flywheel: history follows the prediction so received errors cannot corrupt it.
            r_hist <= {r_hist[8:0], w_pred};
            if (w_mis) begin
              r_err_pulse <= 1'b1;
              if (clear_err) begin
                r_err_count <= ERR_W'(1);
              end else if (r_err_count != {ERR_W{1'b1}}) begin
                r_err_count <= r_err_count + ERR_W'(1);
              end
            end
            if (w_mis && (w_win_err_nxt >= 8'(LOSS_THRESH))) begin
              r_state     <= StSearch;
              r_locked    <= 1'b0;
              r_match_cnt <= '0;
            end else if (r_win_cnt == 8'(WINDOW - 1)) begin
              r_win_cnt <= '0;
              r_win_err <= '0;
            end else begin
              r_win_cnt <= r_win_cnt + 8'd1;
              r_win_err <= w_win_err_nxt;
            end
          end
          default: r_state <= StFill;
        endcase
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_prbs10_checker.sv
// Scoreboard bench: stimulus pushes the expected post-edge outputs, a monitor pops and compares.
module tb_prbs10_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        clear_err = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  prbs10_checker #(
    .LOCK_COUNT (16),
    .WINDOW     (32),
    .LOSS_THRESH(4),
    .ERR_W      (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .clear_err(clear_err),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count)
  );

  typedef struct packed {
    logic        l;
    logic        p;
    logic [15:0] c;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [9:0]  g;
  int          e;

  // Reference generator: rnd <= {rnd[8:0], ~(rnd[9]^rnd[6])}, stream bit is rnd[0].
  task automatic gen_bit(output logic b);
    g = {g[8:0], ~(g[9] ^ g[6])};
    b = g[0];
  endtask

  task automatic push(input logic l, input logic p, input logic [15:0] c);
    exp_t x;
    x.l = l;
    x.p = p;
    x.c = c;
    sb.push_back(x);
  endtask

  task automatic send(input logic flip, input logic clr, input logic el, input logic ep);
    logic b;
    gen_bit(b);
    reset     = 1'b0;
    bit_in    = b ^ flip;
    bit_valid = 1'b1;
    clear_err = clr;
    push(el, ep, 16'(e));
    @(negedge clk);
  endtask

  task automatic idle(input logic el);
    reset     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b1;
    clear_err = 1'b0;
    push(el, 1'b0, 16'(e));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bit_valid = 1'b0;
    clear_err = 1'b0;
    e         = 0;
    g         = 10'b0000000001;
    push(1'b0, 1'b0, 16'd0);
    @(negedge clk);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        checks += 3;
        if (locked !== x.l) begin
          errors++;
          $display("FAIL locked t=%0t got=%b want=%b", $time, locked, x.l);
        end
        if (err_pulse !== x.p) begin
          errors++;
          $display("FAIL err_pulse t=%0t got=%b want=%b", $time, err_pulse, x.p);
        end
        if (err_count !== x.c) begin
          errors++;
          $display("FAIL err_count t=%0t got=%0d want=%0d", $time, err_count, x.c);
        end
      end
    end
  end

  initial begin
    int pos;
    logic f;
    // Clean lock: 10 fill + 16 matching bits.
    do_reset();
    for (int i = 0; i < 26; i++) send(1'b0, 1'b0, i == 25, 1'b0);

    // Single error while locked, flywheel keeps the following bits clean.
    e = 1;
    send(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) send(1'b0, 1'b0, 1'b1, 1'b0);
    // Finish the window (21 of 32 bits used).
    for (int i = 0; i < 11; i++) send(1'b0, 1'b0, 1'b1, 1'b0);

    // Four errors in one window drop lock on the fourth.
    for (int i = 0; i < 7; i++) begin
      f = (i % 2) == 0;
      if (f) e++;
      send(f, 1'b0, !(i == 6), f);
    end
    // History retained: 16 clean bits relock without refilling.
    for (int i = 0; i < 16; i++) send(1'b0, 1'b0, i == 15, 1'b0);

    // Three errors per window for five windows stays locked.
    for (int i = 0; i < 160; i++) begin
      pos = i % 32;
      f = (pos == 0) || (pos == 10) || (pos == 20);
      if (f) e++;
      send(f, 1'b0, 1'b1, f);
    end

    // Constant ones: history sticks at the lock-up state, never locks.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      reset = 1'b0; bit_in = 1'b1; bit_valid = 1'b1; clear_err = 1'b0;
      push(1'b0, 1'b0, 16'd0);
      @(negedge clk);
    end

    // Sparse valid: one valid bit every third cycle.
    do_reset();
    for (int i = 0; i < 26; i++) begin
      send(1'b0, 1'b0, i == 25, 1'b0);
      idle(i == 25);
      idle(i == 25);
    end

    // Build err_count=5 without losing lock, then clear coincident with an error.
    for (int i = 0; i < 3; i++) begin e++; send(1'b1, 1'b0, 1'b1, 1'b1); end
    for (int i = 0; i < 29; i++) send(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin e++; send(1'b1, 1'b0, 1'b1, 1'b1); end
    e = 1;
    send(1'b1, 1'b1, 1'b1, 1'b1);
    e = 0;
    send(1'b0, 1'b1, 1'b1, 1'b0);

    // Reset while locked, then the full 26 bits are needed again.
    do_reset();
    for (int i = 0; i < 26; i++) send(1'b0, 1'b0, i == 25, 1'b0);

    bit_valid = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prbs10_checker.md
Name: prbs10_checker

Overview:
Serial receive-side checker for the 10-bit XNOR LFSR random stream (taps Q10/Q7, feedback ~(s[9]^s[6])). It consumes one stream bit per valid cycle, self-synchronises to the sequence and declares lock. Once locked, it flywheels its own prediction and counts bit errors. It sits at the far end of the game's link and gives the game logic lock status and an error count.

Parameters:
LOCK_COUNT, 16, consecutive correct predictions in SEARCH required to assert lock (1..255)
WINDOW, 32, valid-bit window length for loss-of-lock evaluation while LOCKED (2..255)
LOSS_THRESH, 4, errors within one WINDOW that force loss of lock (1..WINDOW)
ERR_W, 16, width of the saturating error counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
bit_in  input  1  stream bit (the generator's newly inserted bit, rnd[0] after each step)
bit_valid  input  1  qualifies bit_in; the bit is sampled only on cycles where this is 1
clear_err  input  1  synchronous clear of err_count
locked  output  1  1 while in LOCKED
err_pulse  output  1  one-cycle pulse following a mismatched bit while LOCKED
err_count  output  ERR_W  saturating total error count

Behaviour:
- Reset (sync, active-high, highest priority): state=FILL, history=0, fill/match/window/window_err counters=0, locked=0, err_pulse=0, err_count=0.
- Stream rule: history h[9:0], newest bit in h[0]. Prediction p = ~(h[9]^h[6]). The shift is h <= {h[8:0], x}.
- Cycles with bit_valid=0: no state or counter changes. err_pulse=0.
- FILL: each valid bit shifts x=bit_in and increments fill_cnt. No comparison. On the 10th valid bit go to SEARCH with match_cnt=0.
- SEARCH: each valid bit shifts x=bit_in (self-synchronising).
  - If h==10'h3FF (illegal XNOR lock-up state), match_cnt=0 regardless of compare.
  - Else if bit_in==p, match_cnt++.
  - Else match_cnt=0.
  - When the increment reaches LOCK_COUNT, go to LOCKED: locked=1, window_cnt=0, window_err=0. This takes effect on the same edge.
  - No errors are counted in SEARCH.
- LOCKED: each valid bit shifts x=p (flywheel), so received errors do not corrupt history.
  - Mismatch (bit_in!=p): err_pulse=1 next cycle, err_count++ (saturates at all ones), window_err++.
  - Loss check uses the updated window_err. If it reaches LOSS_THRESH, go to SEARCH on that edge: locked=0, match_cnt=0. History is retained; FILL is not re-entered.
  - Otherwise window_cnt++. On the WINDOW-th valid bit, window_cnt=0 and window_err=0. An error on that last bit counts toward the loss check before the clear.
- clear_err: err_count=0. If a counted error occurs on the same edge, err_count=1 (clear first, then count). clear_err does not affect lock or window state.
- All outputs are registered and change only on the edge that samples a valid bit (or reset/clear). Latency from a sampled bit to its locked/err_pulse/err_count effect is 1 cycle.
- Clean-stream lock time from reset: 10 + LOCK_COUNT valid bits.

Test Plan:
- Generator seeded 10'b0000000001 feeding every cycle; reset then 26 valid bits -> locked=0 through bit 25, locked=1 the cycle after bit 26; err_count=0, err_pulse never high.
- Locked; invert one bit -> err_pulse high exactly one cycle, err_count=1, locked stays 1; next 20 clean bits produce no further errors (flywheel intact).
- Locked; invert 4 bits within one 32-bit window -> locked=0 the cycle after the 4th error, err_count=4. Then 16 clean bits -> locked=1 again. Separately, 3 errors per window for 5 windows -> locked stays 1, err_count=15.
- Constant all-ones bit_in for 40 valid bits after reset -> locked stays 0, err_count=0.
- bit_valid asserted every 3rd cycle, clean stream -> locked asserts after the 26th valid bit; outputs unchanged on idle cycles.
- Locked with err_count=5: clear_err together with an error bit -> err_count=1. Then assert reset while locked -> next cycle locked=0, err_count=0, and 26 valid bits are again required to relock.
